riscv_regfile_sb: RTL

- Parametrised RV32I/RV32E integer register file: configurable depth, data width and read-port count.
- Adds write-to-read bypass and a per-register busy scoreboard that tracks issued-but-unwritten destinations and raises a stall.
- Sits between decode (rs reads, rd issue) and writeback (rd write) of the pipelined core; replaces the fixed 2R1W regfile.

---
 rtl/riscv_regfile_sb.sv | 97 +++++++++
 1 files changed

// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb: parametrised RV32I/RV32E integer register file with
// write-to-read bypass and a per-register busy scoreboard that flags
// operands whose producer has issued but not yet written back.
module riscv_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRP    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG),
    localparam int CW    = $clog2(NREG + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NRP*AW-1:0]   i_regfile_rs_addr,
    input  logic [NRP-1:0]      i_regfile_rs_en,
    output logic [NRP*XLEN-1:0] o_regfile_rs_data,
    output logic [NRP-1:0]      o_regfile_rs_busy,
    output logic                o_regfile_stall,
    input  logic [AW-1:0]       i_regfile_rd_addr,
    input  logic [XLEN-1:0]     i_regfile_rd_data,
    input  logic                i_regfile_rd_wen,
    input  logic [AW-1:0]       i_regfile_issue_addr,
    input  logic                i_regfile_issue_en,
    output logic [CW-1:0]       o_regfile_busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [CW-1:0]   cnt_next;
    logic            write_ok;
    logic            issue_ok;

    // x0 is hardwired, so writes and issues aimed at it never take effect
    assign write_ok = i_regfile_rd_wen && (i_regfile_rd_addr != '0);
    assign issue_ok = i_regfile_issue_en && (i_regfile_issue_addr != '0);

    // Register storage: cleared on reset, one-cycle write latency
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[i_regfile_rd_addr] <= i_regfile_rd_data;
        end
    end

    // Next busy vector: writeback clears, issue sets afterwards so a newer producer wins
    always_comb begin
        busy_next = busy;
        if (i_regfile_rd_wen) begin
            busy_next[i_regfile_rd_addr] = 1'b0;
        end
        if (issue_ok) begin
            busy_next[i_regfile_issue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Population count of the post-edge busy vector; x0 is never busy so it is skipped
    always_comb begin
        cnt_next = '0;
        for (int i = 1; i < NREG; i++) begin
            cnt_next = cnt_next + CW'(busy_next[i]);
        end
    end

    // Scoreboard state and its registered busy count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy               <= '0;
            o_regfile_busy_cnt <= '0;
        end else begin
            busy               <= busy_next;
            o_regfile_busy_cnt <= cnt_next;
        end
    end

    // Per-port combinational read with optional same-cycle forwarding of the writeback
    for (genvar k = 0; k < NRP; k++) begin : g_port
        logic [AW-1:0] addr;
        logic          bypass_hit;

        assign addr       = i_regfile_rs_addr[k*AW +: AW];
        assign bypass_hit = (BYPASS != 0) && i_regfile_rd_wen && (i_regfile_rd_addr == addr);

        assign o_regfile_rs_data[k*XLEN +: XLEN] = (addr == '0) ? '0 :
                                                   bypass_hit   ? i_regfile_rd_data :
                                                                  regs[addr];
        assign o_regfile_rs_busy[k] = busy[addr] & ~bypass_hit;
    end

    // Stall only when a port actually uses a pending operand
    assign o_regfile_stall = |(i_regfile_rs_en & o_regfile_rs_busy);

endmodule
